// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin arbiter with bounded lock in front of a 2**AW x DW
//             single-ported data memory shared by core (A) and loader (B).
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          rvalid_a,
    output logic          rvalid_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          conflict
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    localparam int         c_DEPTH    = 2**AW;
    localparam logic [3:0] c_MAX_LOCK = 4'(MAX_LOCK);

    owner_t        r_owner, w_owner_nxt;
    logic [3:0]    r_lock_cnt, w_lock_cnt_nxt;
    logic          r_last_b, w_last_b_nxt;
    logic          w_gnt_a, w_gnt_b, w_break;
    logic          w_held_a, w_held_b, w_sat;
    logic          r_rvalid_a, r_rvalid_b;
    logic [DW-1:0] r_rdata_a, r_rdata_b;
    logic [DW-1:0] r_mem [c_DEPTH];

    logic          w_acc_en, w_acc_we;
    logic [AW-1:0] w_acc_addr;
    logic [DW-1:0] w_acc_wdata, w_rd_word;

    assign w_held_a = (r_owner == OWN_A) && req_a;
    assign w_held_b = (r_owner == OWN_B) && req_b;
    assign w_sat    = (r_lock_cnt == c_MAX_LOCK);

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        w_break = 1'b0;
        if (!sys_rst) begin
            if (req_a && !req_b) begin
                w_gnt_a = 1'b1;
            end else if (req_b && !req_a) begin
                w_gnt_b = 1'b1;
            end else if (req_a && req_b) begin
                if (w_held_a) begin
                    w_break = w_sat;
                    w_gnt_a = !w_sat;
                    w_gnt_b = w_sat;
                end else if (w_held_b) begin
                    w_break = w_sat;
                    w_gnt_b = !w_sat;
                    w_gnt_a = w_sat;
                end else begin
                    w_gnt_a = r_last_b;
                    w_gnt_b = !r_last_b;
                end
            end
        end
    end

    always_comb begin
        w_owner_nxt    = r_owner;
        w_lock_cnt_nxt = r_lock_cnt;
        w_last_b_nxt   = r_last_b;
        // Owner walking away from the memory gives the lock up.
        if ((r_owner == OWN_A && !req_a) || (r_owner == OWN_B && !req_b)) begin
            w_owner_nxt    = OWN_NONE;
            w_lock_cnt_nxt = 4'd0;
        end
        if (w_gnt_a) w_last_b_nxt = 1'b0;
        if (w_gnt_b) w_last_b_nxt = 1'b1;
        if (w_break) begin
            w_owner_nxt    = OWN_NONE;
            w_lock_cnt_nxt = 4'd0;
        end else if (w_gnt_a) begin
            if (lock_a) begin
                w_owner_nxt    = OWN_A;
                w_lock_cnt_nxt = (r_owner != OWN_A) ? 4'd1 :
                                 (r_lock_cnt >= c_MAX_LOCK) ? c_MAX_LOCK : r_lock_cnt + 4'd1;
            end else begin
                w_owner_nxt    = OWN_NONE;
                w_lock_cnt_nxt = 4'd0;
            end
        end else if (w_gnt_b) begin
            if (lock_b) begin
                w_owner_nxt    = OWN_B;
                w_lock_cnt_nxt = (r_owner != OWN_B) ? 4'd1 :
                                 (r_lock_cnt >= c_MAX_LOCK) ? c_MAX_LOCK : r_lock_cnt + 4'd1;
            end else begin
                w_owner_nxt    = OWN_NONE;
                w_lock_cnt_nxt = 4'd0;
            end
        end
    end

    assign w_acc_en    = w_gnt_a | w_gnt_b;
    assign w_acc_we    = w_gnt_a ? we_a    : we_b;
    assign w_acc_addr  = w_gnt_a ? addr_a  : addr_b;
    assign w_acc_wdata = w_gnt_a ? wdata_a : wdata_b;
    assign w_rd_word   = r_mem[w_acc_addr];

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_owner    <= OWN_NONE;
            r_lock_cnt <= 4'd0;
            r_last_b   <= 1'b1;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_last_b   <= w_last_b_nxt;
            r_rvalid_a <= w_gnt_a & ~we_a;
            r_rvalid_b <= w_gnt_b & ~we_b;
            if (w_acc_en && w_acc_we) r_mem[w_acc_addr] <= w_acc_wdata;
            if (w_gnt_a && !we_a)     r_rdata_a <= w_rd_word;
            if (w_gnt_b && !we_b)     r_rdata_b <= w_rd_word;
        end
    end

    assign gnt_a    = w_gnt_a;
    assign gnt_b    = w_gnt_b;
    assign conflict = req_a & req_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed vector table plus lock sequences for dmem_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        gnt_a, gnt_b, rvalid_a, rvalid_b, conflict;
    logic [15:0] rdata_a, rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter #(.DW(16), .AW(4), .MAX_LOCK(4)) u_dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .we_a     (we_a),
        .we_b     (we_b),
        .lock_a   (lock_a),
        .lock_b   (lock_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .wdata_a  (wdata_a),
        .wdata_b  (wdata_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .conflict (conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, ra, rb, wa, wb, la, lb;
        logic [3:0]  aa, ab;
        logic [15:0] da, db;
        logic        ga, gb, cf, va, vb;
        logic [15:0] rda, rdb;
    } vec_t;

    localparam int c_NVEC = 22;
    vec_t tbl [c_NVEC];

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ra, input logic rb, input logic la, input logic lb);
        @(negedge clk);
        sys_rst = 1'b0;
        req_a = ra; req_b = rb; lock_a = la; lock_b = lb;
        we_a = 1'b0; we_b = 1'b0; addr_a = 4'd1; addr_b = 4'd2;
        wdata_a = 16'h0; wdata_b = 16'h0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        lock_a = 1'b0; lock_b = 1'b0; addr_a = 4'd0; addr_b = 4'd0;
        wdata_a = 16'h0; wdata_b = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        //            rst   ra    rb    wa    wb    la    lb    aa    ab    da        db        ga    gb    cf    va    vb    rda       rdb
        tbl[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'h0,4'h0,16'h1111,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,4'h3,4'h0,16'h1234,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h3,4'h0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'h1234,16'h0000};
        tbl[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h1234,16'h0000};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'h0000,16'h0000};
        tbl[6]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'h0,4'h1,16'h0000,16'hAAAA,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'h0,4'h2,16'h0000,16'h5555,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h1,4'h2,16'h0000,16'h0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000};
        tbl[9]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h1,4'h2,16'h0000,16'h0000,1'b0,1'b1,1'b1,1'b1,1'b0,16'hAAAA,16'h0000};
        tbl[10] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h1,4'h2,16'h0000,16'h0000,1'b1,1'b0,1'b1,1'b0,1'b1,16'hAAAA,16'h5555};
        tbl[11] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h1,4'h2,16'h0000,16'h0000,1'b0,1'b1,1'b1,1'b1,1'b0,16'hAAAA,16'h5555};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,16'hAAAA,16'h5555};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'h0,4'hF,16'h0000,16'hBEEF,1'b0,1'b1,1'b0,1'b0,1'b0,16'hAAAA,16'h5555};
        tbl[14] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,4'hF,16'h0000,16'h0000,1'b0,1'b0,1'b1,1'b0,1'b0,16'hAAAA,16'h5555};
        tbl[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'h5,4'h5,16'h00FF,16'h0000,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000};
        tbl[16] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,4'h5,16'h0000,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[17] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h0,4'hF,16'h0000,16'h0000,1'b0,1'b1,1'b0,1'b0,1'b1,16'h0000,16'h00FF};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000};
        tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h5,4'h0,16'h0000,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};
        tbl[20] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'h5,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b1,1'b0,16'h00FF,16'h0000};
        tbl[21] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0,4'h0,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000};

        sys_rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
        lock_a = 1'b0; lock_b = 1'b0; addr_a = 4'd0; addr_b = 4'd0;
        wdata_a = 16'h0; wdata_b = 16'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            sys_rst = tbl[i].rst;
            req_a   = tbl[i].ra;  req_b   = tbl[i].rb;
            we_a    = tbl[i].wa;  we_b    = tbl[i].wb;
            lock_a  = tbl[i].la;  lock_b  = tbl[i].lb;
            addr_a  = tbl[i].aa;  addr_b  = tbl[i].ab;
            wdata_a = tbl[i].da;  wdata_b = tbl[i].db;
            #1;
            check("gnt_a",    i, {15'd0, gnt_a},    {15'd0, tbl[i].ga});
            check("gnt_b",    i, {15'd0, gnt_b},    {15'd0, tbl[i].gb});
            check("conflict", i, {15'd0, conflict}, {15'd0, tbl[i].cf});
            check("rvalid_a", i, {15'd0, rvalid_a}, {15'd0, tbl[i].va});
            check("rvalid_b", i, {15'd0, rvalid_b}, {15'd0, tbl[i].vb});
            check("rdata_a",  i, rdata_a, tbl[i].rda);
            check("rdata_b",  i, rdata_b, tbl[i].rdb);
        end

        // B locks against continuous A traffic: A, then BBBB, A, BBBB, A.
        do_reset();
        for (int c = 0; c < 11; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            check("lockb_gnt_a", c, {15'd0, gnt_a}, {15'd0, ((c % 5) == 0)});
            check("lockb_gnt_b", c, {15'd0, gnt_b}, {15'd0, ((c % 5) != 0)});
        end

        // Uncontended A lock for 10 cycles; saturated count then yields at once.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            check("solo_gnt_a", c, {15'd0, gnt_a}, 16'd1);
        end
        for (int c = 10; c < 16; c++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            check("sat_gnt_a", c, {15'd0, gnt_a}, {15'd0, (c != 10 && c != 15)});
            check("sat_gnt_b", c, {15'd0, gnt_b}, {15'd0, (c == 10 || c == 15)});
        end

        // Dropping req releases the lock, so round-robin picks B next.
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("rel_gnt_a0", 0, {15'd0, gnt_a}, 16'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("rel_idle", 1, {14'd0, gnt_a, gnt_b}, 16'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("rel_gnt_b", 2, {15'd0, gnt_b}, 16'd1);
        check("rel_gnt_a", 2, {15'd0, gnt_a}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 16-word x 16-bit data memory of the processor. It shares one single-ported memory array, held inside the block, between two requesters:
- port A: the core's store/load path.
- port B: the host/debug loader that preloads operands and reads results over the din/dout path.

Conflicts resolve round-robin. An optional bounded lock lets one requester perform back-to-back accesses without interleaving.

## Interface
Parameters:
- DW, 16: data word width.
- AW, 4: address width; memory depth is 2**AW words.
- MAX_LOCK, 4: maximum consecutive locked grants before a contending requester is forced in (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- req_a / req_b  in  1  access request, port A / B.
- we_a / we_b  in  1  1 = write, 0 = read.
- lock_a / lock_b  in  1  request to keep the grant on the following cycle.
- addr_a / addr_b  in  AW  word address.
- wdata_a / wdata_b  in  DW  write data.
- gnt_a / gnt_b  out  1  combinational grant; the access commits at the next rising edge.
- rvalid_a / rvalid_b  out  1  registered; read data valid, one cycle after a granted read.
- rdata_a / rdata_b  out  DW  registered read data.
- conflict  out  1  combinational; both req_a and req_b high in this cycle.

## Operation
- Grant rule (evaluated every cycle, in priority order):
  - No request: no grant.
  - Exactly one request: that requester is granted.
  - Both requesting and a lock is held: the lock owner is granted.
  - Both requesting, no lock: the requester that was not the last one granted.
- Lock state:
  - owner: none / A / B.
  - lock_cnt: 4 bits.
  - Lock is held when the owner was granted last cycle with its lock input high, and the owner is requesting now.
- Lock bookkeeping on each grant:
  - If the granted port's lock input is high: owner becomes that port, and lock_cnt increments if the previous grant was also locked by that same port, otherwise loads 1.
  - If its lock input is low: owner becomes none and lock_cnt clears.
  - lock_cnt saturates at MAX_LOCK.
- Lock break: when lock_cnt == MAX_LOCK and the other port is requesting, the lock is ignored. The other port is granted, and owner and lock_cnt clear.
  - If the other port is not requesting, the owner keeps the grant.
- last_grant updates on every grant. Its reset value is B, so A wins the first conflict.
- Write: mem[addr] <= wdata at the granting edge.
- Read: rdata_x <= mem[addr] at the granting edge, and rvalid_x pulses high for one cycle.
  - rdata_x holds its value when rvalid_x is low.
- A write followed by a read of the same address on the next cycle returns the new data. There is no read-during-write hazard, because only one port accesses the memory per cycle.
- An ungranted requester must hold req, we, addr and wdata stable until granted. The block does not queue requests.

## Timing
- Grant: same cycle as the request (combinational from the request inputs and registered state).
- Read latency: one clock from the granting edge to rvalid.
- Throughput: one access per cycle in total; each port gets at least one grant in every MAX_LOCK+1 cycles while contending.
- Reset (sys_rst high at an edge), takes priority over everything:
  - gnt_a = gnt_b = 0 while sys_rst is high.
  - rvalid_a = rvalid_b = 0, rdata_a = rdata_b = 0.
  - owner = none, lock_cnt = 0, last_grant = B.
  - All memory words cleared to 0.
  - A read granted in the cycle before reset still delivers its rvalid pulse; any access in the reset cycle itself is dropped.
- Boundary behaviour:
  - Address 2**AW-1: valid. There is no wrap-around or address checking.
  - A port that drops req while holding a lock releases it: owner and lock_cnt clear.

## Test plan
- Reset, then A writes 0x1234 to address 3, then A reads address 3 -> gnt_a high in the same cycle as each request; rvalid_a high one cycle after the read grant with rdata_a = 0x1234; rvalid_b stays 0.
- Both ports request every cycle with no lock, reads of addresses 1 (A) and 2 (B) -> grants alternate A, B, A, B; conflict = 1 in every cycle.
- B holds lock_b = 1 with continuous requests and A requests continuously, MAX_LOCK = 4 -> B is granted 4 consecutive cycles, then A for one cycle, then B regains and locks again.
- Lock with no contention: A locks for 10 cycles and req_b = 0 -> A is granted all 10 cycles; lock_cnt saturates at 4 and never exceeds it.
- Write to address 15 (0xBEEF) by B, then sys_rst pulsed, then B reads address 15 -> rdata_b = 0x0000; gnt and rvalid are 0 during reset.
- Same-cycle conflict with A writing 0x00FF and B reading address 5, first conflict after reset -> A granted first; B's read on the next cycle returns 0x00FF.
